// File: rtl/scene_pkg.sv
// Shared types and defaults for the scene controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scene_pkg;

    // Encoded width of the controller state.
    localparam int STATE_W = 3;

    // Default clear colour {R,G,B} and clear depth.
    localparam logic [23:0] BG_RGB_DEF = 24'h000000;
    localparam logic [7:0]  Z_FAR_DEF  = 8'hFF;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } scene_state_t;

endpackage

// File: rtl/scene_key_edge.sv
// Registers the start key and flags its rising edge.
// Latency: rise is combinational on key against the previous-cycle value.
// Backpressure: none; a held key yields exactly one pulse.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic key_q;

    // Previous key value; resets high so a key held through reset is not a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key;
        end
    end

    assign rise = key & ~key_q;

endmodule

// File: rtl/scene_ctrl.sv
// Frame sequencer: optional buffer clear, then one 4-phase handshake per triangle.
// Latency: start edge seen -> CLEAR/ISSUE next cycle; 2**FB_AW clear cycles when enabled.
// Backpressure: ISSUE holds req_1 until ack_1; WAIT_LO holds until ack_1 drops.
// Build option: define SCENE_CLEAR_EN to include the frame/Z buffer clear phase.
module scene_ctrl
    import scene_pkg::*;
#(
    parameter int          N_TRI  = 16,
    parameter int          ROM_AW = 4,
    parameter int          FB_AW  = 16,
    parameter logic [23:0] BG_RGB = BG_RGB_DEF,
    parameter logic [7:0]  Z_FAR  = Z_FAR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key1,
    output logic              req_1,
    input  logic              ack_1,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              clr_we,
    output logic [FB_AW-1:0]  clr_addr,
    output logic [23:0]       clr_rgb,
    output logic [7:0]        clr_z,
    output logic              busy,
    output logic              frame_done
);

    // Index of the final triangle; the counter stops here rather than wrapping.
    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(N_TRI - 1);

    scene_state_t      state;
    scene_state_t      state_nxt;
    logic [ROM_AW-1:0] idx;
    logic              start;

    key_edge u_key_edge (
        .clk  (clk),
        .rst  (rst),
        .key  (key1),
        .rise (start)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nxt  = state;
        req_1      = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        clr_we     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
`ifdef SCENE_CLEAR_EN
                    state_nxt = S_CLEAR;
`else
                    state_nxt = S_ISSUE;
`endif
                end
            end
            S_CLEAR: begin
`ifdef SCENE_CLEAR_EN
                clr_we = 1'b1;
                if (clr_addr == {FB_AW{1'b1}}) begin
                    state_nxt = S_ISSUE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            S_ISSUE: begin
                req_1 = 1'b1;
                if (ack_1) begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!ack_1) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nxt = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Triangle index: advances only in NEXT, so it never moves while req_1 is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state == S_DONE) begin
            idx <= '0;
        end else if (state == S_NEXT && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
        end
    end

    assign rom_addr = idx;

`ifdef SCENE_CLEAR_EN
    logic [FB_AW-1:0] clr_cnt;

    // Clear address: sweeps every location once, wrapping back to 0 on exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    assign clr_addr = clr_cnt;
`else
    assign clr_addr = '0;
`endif

    assign clr_rgb = BG_RGB;
    assign clr_z   = Z_FAR;

endmodule
